// File: rtl/uart_cfg.sv
`timescale 1ns/1ps
// uart_cfg: 16x-oversampled UART with run-time divisor, optional parity, 1/2 stop bits and FWFT FIFOs.
// Writes to a full tx FIFO and reads from an empty rx FIFO are dropped; rx words arriving while full raise overrun.

module uart_cfg_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] w_data,
    input  logic         rd,
    output logic [W-1:0] r_data,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          do_wr, do_rd;

    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign do_rd  = rd && !empty;
    // a read frees the slot in the same clock, so a full FIFO still accepts a paired write
    assign do_wr  = wr && (!full || rd);
    assign r_data = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= w_data;
                wptr      <= wptr + 1'b1;
            end
            if (do_rd) rptr <= rptr + 1'b1;
            if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
            else if (!do_wr && do_rd) cnt <= cnt - 1'b1;
        end
    end
endmodule

module uart_cfg #(
    parameter int DBIT     = 8,
    parameter int FIFO_W   = 2,
    parameter int DVSR_BIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic                parity_en,
    input  logic                parity_odd,
    input  logic                stop2,
    input  logic                rx,
    output logic                tx,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    output logic                tx_empty,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_empty,
    input  logic                clr_err,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun
);
    localparam int NW = $clog2(DBIT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DVSR_BIT-1:0] tick_cnt;
    logic                tick;
    logic                rx_meta, rx_s;

    assign tick = (tick_cnt >= dvsr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            rx_meta  <= rx;
            rx_s     <= rx_meta;
        end
    end

    // receiver
    state_t          rx_state, rx_state_n;
    logic [3:0]      rx_cnt, rx_cnt_n;
    logic [NW-1:0]   rx_n, rx_n_n;
    logic [DBIT-1:0] rx_shift, rx_shift_n;
    logic            rx_pen, rx_pen_n, rx_podd, rx_podd_n, rx_pbad, rx_pbad_n;
    logic            rx_done, rx_full, rx_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_n     <= '0;
            rx_shift <= '0;
            rx_pen   <= 1'b0;
            rx_podd  <= 1'b0;
            rx_pbad  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_n     <= rx_n_n;
            rx_shift <= rx_shift_n;
            rx_pen   <= rx_pen_n;
            rx_podd  <= rx_podd_n;
            rx_pbad  <= rx_pbad_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_n_n     = rx_n;
        rx_shift_n = rx_shift;
        rx_pen_n   = rx_pen;
        rx_podd_n  = rx_podd;
        rx_pbad_n  = rx_pbad;
        rx_done    = 1'b0;
        case (rx_state)
            S_IDLE: if (!rx_s) begin
                rx_state_n = S_START;
                rx_cnt_n   = '0;
                rx_pen_n   = parity_en;
                rx_podd_n  = parity_odd;
                rx_pbad_n  = 1'b0;
            end
            S_START: if (tick) begin
                if (rx_cnt == 4'd7) begin
                    rx_cnt_n   = '0;
                    rx_n_n     = '0;
                    rx_state_n = rx_s ? S_IDLE : S_DATA;
                end else rx_cnt_n = rx_cnt + 4'd1;
            end
            S_DATA: if (tick) begin
                if (rx_cnt == 4'd15) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[DBIT-1:1]};
                    if (rx_n == NW'(DBIT - 1)) rx_state_n = rx_pen ? S_PAR : S_STOP;
                    else                       rx_n_n     = rx_n + 1'b1;
                end else rx_cnt_n = rx_cnt + 4'd1;
            end
            S_PAR: if (tick) begin
                if (rx_cnt == 4'd15) begin
                    rx_cnt_n   = '0;
                    rx_pbad_n  = rx_s ^ (^rx_shift) ^ rx_podd;
                    rx_state_n = S_STOP;
                end else rx_cnt_n = rx_cnt + 4'd1;
            end
            S_STOP: if (tick) begin
                if (rx_cnt == 4'd15) begin
                    rx_done    = 1'b1;
                    rx_state_n = S_IDLE;
                end else rx_cnt_n = rx_cnt + 4'd1;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // rx_s at rx_done is the sampled stop bit
    assign rx_push = rx_done && rx_s && !rx_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= (rx_push && rx_pbad)          | (parity_err & ~clr_err);
            frame_err  <= (rx_done && !rx_s)            | (frame_err  & ~clr_err);
            overrun    <= (rx_done && rx_s && rx_full)  | (overrun    & ~clr_err);
        end
    end

    uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset(reset), .wr(rx_push), .w_data(rx_shift),
        .rd(rd_uart), .r_data(r_data), .full(rx_full), .empty(rx_empty)
    );

    // transmitter
    state_t          tx_state, tx_state_n;
    logic [4:0]      tx_cnt, tx_cnt_n;
    logic [NW-1:0]   tx_n, tx_n_n;
    logic [DBIT-1:0] tx_shift, tx_shift_n, tx_head;
    logic            tx_pen, tx_pen_n, tx_stop2, tx_stop2_n, tx_pbit, tx_pbit_n;
    logic            tx_reg, tx_next, tx_pop;

    assign tx = tx_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_n     <= '0;
            tx_shift <= '0;
            tx_pen   <= 1'b0;
            tx_stop2 <= 1'b0;
            tx_pbit  <= 1'b0;
            tx_reg   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_n     <= tx_n_n;
            tx_shift <= tx_shift_n;
            tx_pen   <= tx_pen_n;
            tx_stop2 <= tx_stop2_n;
            tx_pbit  <= tx_pbit_n;
            tx_reg   <= tx_next;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_n_n     = tx_n;
        tx_shift_n = tx_shift;
        tx_pen_n   = tx_pen;
        tx_stop2_n = tx_stop2;
        tx_pbit_n  = tx_pbit;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: if (tick && !tx_empty) tx_pop = 1'b1;
            S_START: if (tick) begin
                if (tx_cnt == 5'd15) begin
                    tx_cnt_n   = '0;
                    tx_n_n     = '0;
                    tx_state_n = S_DATA;
                end else tx_cnt_n = tx_cnt + 5'd1;
            end
            S_DATA: if (tick) begin
                if (tx_cnt == 5'd15) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_n == NW'(DBIT - 1)) tx_state_n = tx_pen ? S_PAR : S_STOP;
                    else                       tx_n_n     = tx_n + 1'b1;
                end else tx_cnt_n = tx_cnt + 5'd1;
            end
            S_PAR: if (tick) begin
                if (tx_cnt == 5'd15) begin
                    tx_cnt_n   = '0;
                    tx_state_n = S_STOP;
                end else tx_cnt_n = tx_cnt + 5'd1;
            end
            S_STOP: if (tick) begin
                if (tx_cnt == (tx_stop2 ? 5'd31 : 5'd15)) begin
                    // chain straight into the next frame when one is waiting
                    if (!tx_empty) tx_pop     = 1'b1;
                    else           tx_state_n = S_IDLE;
                end else tx_cnt_n = tx_cnt + 5'd1;
            end
            default: tx_state_n = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_n = S_START;
            tx_cnt_n   = '0;
            tx_shift_n = tx_head;
            tx_pen_n   = parity_en;
            tx_stop2_n = stop2;
            tx_pbit_n  = (^tx_head) ^ parity_odd;
        end
        case (tx_state_n)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = tx_shift_n[0];
            S_PAR:   tx_next = tx_pbit_n;
            default: tx_next = 1'b1;
        endcase
    end

    uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset(reset), .wr(wr_uart), .w_data(w_data),
        .rd(tx_pop), .r_data(tx_head), .full(tx_full), .empty(tx_empty)
    );
endmodule

// File: tb/tb_uart_cfg.sv
`timescale 1ns/1ps
// Directed bench for uart_cfg: tick timing, rx frame table, loopback, glitch, overrun, tx full, async reset.
module tb_uart_cfg;
    localparam int BITC = 64;   // clocks per bit at dvsr=3

    logic       clk, reset;
    logic [7:0] dvsr;
    logic       parity_en, parity_odd, stop2;
    logic       rx, tx, rx_drv, loop;
    logic       wr_uart, tx_full, tx_empty, rd_uart, rx_empty, clr_err;
    logic [7:0] w_data, r_data;
    logic       parity_err, frame_err, overrun;

    assign rx = loop ? tx : rx_drv;

    uart_cfg #(.DBIT(8), .FIFO_W(2), .DVSR_BIT(8)) dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .rx(rx), .tx(tx),
        .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .tx_empty(tx_empty),
        .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty), .clr_err(clr_err),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        w_data = d; wr_uart = 1'b1; cyc(1); wr_uart = 1'b0;
    endtask

    task automatic pop_rx();
        rd_uart = 1'b1; cyc(1); rd_uart = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic sbit);
        rx_drv = 1'b0; cyc(BITC);
        for (int i = 0; i < 8; i++) begin rx_drv = d[i]; cyc(BITC); end
        if (pen) begin rx_drv = pbit; cyc(BITC); end
        rx_drv = sbit; cyc(48);
        rx_drv = 1'b1; cyc(80);
    endtask

    task automatic wait_fall(input int bound, output logic found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
    endtask

    // called on the first clock of a start bit; returns positioned mid stop bit
    task automatic get_byte(output logic [7:0] b);
        b = '0;
        cyc(32);
        for (int k = 0; k < 8; k++) begin cyc(BITC); b[k] = tx; end
        cyc(BITC);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       pen, podd, pbit, sbit;
        logic       exp_empty;
        logic [7:0] exp_d;
        logic       exp_perr, exp_ferr;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] bs [6];
    logic [7:0] a5, b;
    logic       f;
    int         lows;

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0};  // even, bit inverted
        vecs[2] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0};
        vecs[3] = '{8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};  // stop low
        vecs[4] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0};
        bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        a5 = 8'hA5;

        reset = 1'b1; dvsr = 8'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        rx_drv = 1'b1; loop = 1'b0; wr_uart = 1'b0; w_data = '0; rd_uart = 1'b0; clr_err = 1'b0;
        cyc(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_full", 32'(tx_full), 32'd0);
        check("rst_tx_empty", 32'(tx_empty), 32'd1);
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        check("rst_r_data", 32'(r_data), 32'd0);
        check("rst_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
        reset = 1'b0;
        cyc(5);

        // bit timing at dvsr=3 and back-to-back frames
        push_tx(8'hA5);
        wait_fall(50, f);
        check("tick_start_found", 32'(f), 32'd1);
        check("tick_tx_empty_at_start", 32'(tx_empty), 32'd1);
        cyc(63);
        check("tick_start_last", 32'(tx), 32'd0);
        cyc(1);
        check("tick_bit0_first", 32'(tx), 32'd1);
        push_tx(8'h0F);
        cyc(31);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("tick_bit%0d", k), 32'(tx), 32'(a5[k]));
            cyc(BITC);
        end
        check("tick_stop_mid", 32'(tx), 32'd1);
        cyc(31);
        check("tick_frame_end", 32'(tx), 32'd1);
        cyc(1);
        check("tick_b2b_start", 32'(tx), 32'd0);
        cyc(700);

        // injected rx frames
        for (int i = 0; i < 6; i++) begin
            parity_en = vecs[i].pen; parity_odd = vecs[i].podd;
            send_frame(vecs[i].d, vecs[i].pen, vecs[i].pbit, vecs[i].sbit);
            check($sformatf("vec%0d_rx_empty", i), 32'(rx_empty), 32'(vecs[i].exp_empty));
            if (!vecs[i].exp_empty) begin
                check($sformatf("vec%0d_r_data", i), 32'(r_data), 32'(vecs[i].exp_d));
                pop_rx();
                check($sformatf("vec%0d_popped", i), 32'(rx_empty), 32'd1);
            end
            check($sformatf("vec%0d_parity_err", i), 32'(parity_err), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
            pulse_clr();
            check($sformatf("vec%0d_cleared", i), 32'({parity_err, frame_err, overrun}), 32'd0);
        end

        // frame error, then a short low glitch that must be ignored
        parity_en = 1'b0;
        send_frame(8'h3A, 1'b0, 1'b0, 1'b0);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_no_word", 32'(rx_empty), 32'd1);
        rx_drv = 1'b0; cyc(12); rx_drv = 1'b1;
        cyc(200);
        check("glitch_no_word", 32'(rx_empty), 32'd1);
        check("glitch_flags", 32'({parity_err, frame_err, overrun}), 32'b010);
        pulse_clr();

        // loopback with odd parity and two stop bits
        parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1; loop = 1'b1;
        push_tx(8'h00); push_tx(8'hFF); push_tx(8'h3C);
        for (int i = 0; i < 3; i++) begin
            wait_fall(900, f);
            check($sformatf("lb_start%0d", i), 32'(f), 32'd1);
            cyc(32 + 9 * BITC);
            check($sformatf("lb_parity%0d", i), 32'(tx), 32'd1);
        end
        cyc(250);
        check("lb_rx_empty", 32'(rx_empty), 32'd0);
        check("lb_byte0", 32'(r_data), 32'h00);
        pop_rx();
        check("lb_byte1", 32'(r_data), 32'hFF);
        pop_rx();
        check("lb_byte2", 32'(r_data), 32'h3C);
        pop_rx();
        check("lb_drained", 32'(rx_empty), 32'd1);
        check("lb_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
        loop = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        cyc(100);

        // rx overrun and FIFO wrap
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_other_flags", 32'({parity_err, frame_err}), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_read%0d_empty", i), 32'(rx_empty), 32'd0);
            check($sformatf("ovr_read%0d", i), 32'(r_data), 32'(i));
            pop_rx();
        end
        check("ovr_drained", 32'(rx_empty), 32'd1);

        // tx FIFO fill: one word in flight, four more fill it, the sixth is dropped
        push_tx(bs[0]);
        wait_fall(50, f);
        check("txf_start", 32'(f), 32'd1);
        check("txf_popped", 32'(tx_empty), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            push_tx(bs[i]);
            check($sformatf("txf_full_after%0d", i), 32'(tx_full), 32'(i >= 4));
        end
        cyc(600);
        for (int i = 1; i <= 4; i++) begin
            wait_fall(800, f);
            check($sformatf("txf_frame%0d", i), 32'(f), 32'd1);
            get_byte(b);
            check($sformatf("txf_byte%0d", i), 32'(b), 32'(bs[i]));
        end
        wait_fall(900, f);
        check("txf_no_extra_frame", 32'(f), 32'd0);
        check("txf_empty", 32'(tx_empty), 32'd1);

        // async reset in the middle of a data bit
        push_tx(8'h00); push_tx(8'h77);
        wait_fall(50, f);
        check("rst_mid_start", 32'(f), 32'd1);
        cyc(BITC + 20);
        check("rst_mid_low", 32'(tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_tx_empty", 32'(tx_empty), 32'd1);
        check("rst_mid_overrun", 32'(overrun), 32'd0);
        cyc(3);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("rst_idle_line", 32'(lows), 32'd0);
        check("rst_idle_empty", 32'({tx_empty, rx_empty}), 32'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
- Next-generation UART for the design: run-time baud divisor, optional even/odd parity, 1 or 2 stop bits, sticky error flags.
- Rx and tx FIFOs are parametrised and first-word-fall-through (FWFT).
- Integrated in a single module: baud tick generator, 16x-oversampling receiver, transmitter and both FIFOs.
- Sits between the board RX/TX pins and the game-logic controller, which configures it and moves bytes.

Parameters:
- DBIT, 8, data bits per frame (5..8), sent LSB first.
- FIFO_W, 2, FIFO address bits; each FIFO holds 2^FIFO_W words.
- DVSR_BIT, 8, width of the run-time divisor input.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dvsr  in  DVSR_BIT  baud divisor; tick period = dvsr+1 clocks; set to clk/(16*baud)-1.
- parity_en  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even.
- stop2  in  1  1 = transmit two stop bits.
- rx  in  1  serial input, asynchronous.
- tx  out  1  serial output, idle high.
- wr_uart  in  1  push w_data into the tx FIFO.
- w_data  in  DBIT  tx data.
- tx_full  out  1  tx FIFO full.
- tx_empty  out  1  tx FIFO empty.
- rd_uart  in  1  pop the rx FIFO head.
- r_data  out  DBIT  rx FIFO head; valid while rx_empty=0.
- rx_empty  out  1  rx FIFO empty.
- clr_err  in  1  clear all sticky error flags.
- parity_err  out  1  sticky: a received word failed parity.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a received word was dropped because the rx FIFO was full.

Behaviour:
- Reset values:
  - tx=1, tx_full=0, tx_empty=1, rx_empty=1, r_data=0.
  - All error flags 0; both FSMs idle; all counters and FIFO pointers 0.
- Baud tick:
  - Counter increments each clock.
  - When counter >= dvsr: tick=1 for one clock and counter returns to 0.
  - dvsr=0 gives a tick every clock.
  - A dvsr change takes effect at once; no stall if the counter already exceeds the new value.
- rx synchroniser: two flops before any use; adds 2 clocks of latency.
- RX FSM, states idle/start/data/parity/stop, tick-paced:
  - idle → start: on synced rx=0. parity_en and parity_odd are latched here.
  - start: after 7 ticks, resample. rx=1 → back to idle (glitch, nothing logged). rx=0 → data.
  - data: sample every 16 ticks, DBIT samples, LSB first.
  - parity: only when latched parity_en=1. Sample after 16 ticks and compare with the computed parity.
  - stop: sample after 16 ticks, then return to idle. Only one stop bit is checked regardless of stop2.
- RX word disposal at end of stop state:
  - Stop bit=0: set frame_err; discard the word.
  - Otherwise, if the rx FIFO is full: set overrun; discard the word.
  - Otherwise push the word; set parity_err if parity failed. A word with a parity error is still pushed.
- TX FSM, states idle/start/data/parity/stop:
  - idle with tx FIFO not empty: pop the head into a shift register and latch parity_en, parity_odd, stop2.
  - Go to start with tx=0, aligned to the next tick.
  - Each bit lasts 16 ticks: DBIT data bits LSB first, then the optional parity bit, then tx=1 for 16 or 32 ticks.
  - Return to idle after the stop ticks. Back-to-back frames follow with no extra idle bit.
  - Config changes mid-frame affect only the next frame.
- FIFOs:
  - FWFT: head visible on r_data combinationally from the storage read pointer.
  - Write when full is ignored. Read when empty is ignored.
  - Simultaneous read and write on a non-empty, non-full FIFO: count unchanged, pointers both advance.
  - Simultaneous read and write when full: both occur.
  - Simultaneous read and write when empty: write only.
  - Pointers wrap modulo 2^FIFO_W.
- Errors:
  - clr_err clears all three flags in the next clock.
  - A set event in the same clock as clr_err wins; the flag stays 1.
- Reset mid-frame: tx returns to 1 asynchronously and any partial rx word is lost.

Test Plan:
- Tick check: dvsr=3, DBIT=8, parity off, stop2=0, write 0xA5 → tx low for 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, then high; frame totals 640 clocks; tx_empty=1 at start bit.
- Loopback (tx→rx): parity_en=1, parity_odd=1, stop2=1, send 0x00,0xFF,0x3C → r_data yields the same three bytes in order; parity bits sent are 1,1,1; no error flags set.
- Parity error: inject 0x55 with even parity configured but the parity bit inverted → 0x55 appears on r_data and parity_err=1; clr_err → 0 the next clock.
- Frame error plus glitch: inject a frame with stop=0 → frame_err=1 and rx_empty stays 1. Then a 3-tick low pulse on rx → no word and no flag change.
- Overrun and wrap: FIFO_W=2, receive 5 bytes 0x01..0x05 without rd_uart → reads return 0x01..0x04 and overrun=1. Then write 6 bytes to tx → tx_full after the 4th accepted (1 already popped), and the extra write is ignored.
- Async reset asserted mid-tx data bit → tx=1 immediately, tx_empty=1; after release an idle line produces no output.
